// File: rtl/snake_if.sv
// ---------------------------------------------------------------------------
// snake_if : control/query bundle between a game controller and snake_engine
// Rev 1.0  : initial release
// ---------------------------------------------------------------------------
`default_nettype none

interface snake_if #(
  parameter int GRID_W  = 64,
  parameter int GRID_H  = 48,
  parameter int MAX_LEN = 32
);
  localparam int XW = $clog2(GRID_W);
  localparam int YW = $clog2(GRID_H);
  localparam int LW = $clog2(MAX_LEN + 1);

  logic          start;
  logic          tick;
  logic [3:0]    dir_req;
  logic          grow;
  logic [XW-1:0] pix_cx;
  logic [YW-1:0] pix_cy;
  logic [XW-1:0] head_x;
  logic [YW-1:0] head_y;
  logic [LW-1:0] length;
  logic          busy;
  logic          dead;
  logic          step_done;
  logic          pix_head;
  logic          pix_body;

  modport master (
    output start, tick, dir_req, grow, pix_cx, pix_cy,
    input  head_x, head_y, length, busy, dead, step_done, pix_head, pix_body
  );

  modport slave (
    input  start, tick, dir_req, grow, pix_cx, pix_cy,
    output head_x, head_y, length, busy, dead, step_done, pix_head, pix_body
  );
endinterface

`default_nettype wire

// File: rtl/snake_engine.sv
// ---------------------------------------------------------------------------
// snake_engine : single-snake movement, growth and collision engine with a
//                registered per-pixel head/body hit query.
// Rev 1.0      : initial release
// ---------------------------------------------------------------------------
`default_nettype none

module snake_engine #(
  parameter int         MAX_LEN  = 32,
  parameter int         INIT_LEN = 3,
  parameter int         GRID_W   = 64,
  parameter int         GRID_H   = 48,
  parameter int         INIT_X   = 25,
  parameter int         INIT_Y   = 25,
  parameter logic [3:0] INIT_DIR = 4'b1000,
  parameter int         WRAP     = 0
) (
  input  logic     clk,
  input  logic     resetn,
  snake_if.slave   bus
);
  localparam int XW = $clog2(GRID_W);
  localparam int YW = $clog2(GRID_H);
  localparam int LW = $clog2(MAX_LEN + 1);
  localparam int IW = $clog2(MAX_LEN);

  localparam logic [XW-1:0] c_init_x = XW'(INIT_X);
  localparam logic [YW-1:0] c_init_y = YW'(INIT_Y);
  localparam logic [XW-1:0] c_max_x  = XW'(GRID_W - 1);
  localparam logic [YW-1:0] c_max_y  = YW'(GRID_H - 1);
  localparam logic [LW-1:0] c_init_l = LW'(INIT_LEN);
  localparam logic [LW-1:0] c_max_l  = LW'(MAX_LEN);

  typedef enum logic [1:0] {S_INIT, S_RUN, S_SCAN, S_DEAD} state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [XW-1:0] r_seg_x [MAX_LEN];
  logic [YW-1:0] r_seg_y [MAX_LEN];
  logic [LW-1:0] r_len;
  logic [IW-1:0] r_idx;
  logic [3:0]    r_dir;
  logic [3:0]    r_last_dir;
  logic          r_grow_pend;
  logic          r_dead;
  logic          r_step_done;
  logic          r_pix_head;
  logic          r_pix_body;

  logic [3:0]    w_ref_dir;
  logic          w_req_valid;
  logic [XW-1:0] w_nx;
  logic [YW-1:0] w_ny;
  logic          w_out;
  logic          w_step;
  logic          w_wall_death;
  logic          w_scan_hit;
  logic          w_scan_last;
  logic          w_scan_done;
  logic          w_body_hit;

  function automatic logic [3:0] f_rev(input logic [3:0] d);
    return {d[1], d[0], d[3], d[2]};
  endfunction

  assign w_step = (r_state == S_RUN) && bus.tick;

  // A request arriving with the tick is judged against the direction of that step.
  assign w_ref_dir   = w_step ? r_dir : r_last_dir;
  assign w_req_valid = $onehot(bus.dir_req) && (bus.dir_req != f_rev(w_ref_dir));

  always_comb begin
    w_nx  = r_seg_x[0];
    w_ny  = r_seg_y[0];
    w_out = 1'b0;
    if (r_dir[3]) begin
      if (r_seg_x[0] == c_max_x) begin w_out = 1'b1; w_nx = '0; end
      else w_nx = r_seg_x[0] + XW'(1);
    end else if (r_dir[1]) begin
      if (r_seg_x[0] == '0) begin w_out = 1'b1; w_nx = c_max_x; end
      else w_nx = r_seg_x[0] - XW'(1);
    end else if (r_dir[2]) begin
      if (r_seg_y[0] == c_max_y) begin w_out = 1'b1; w_ny = '0; end
      else w_ny = r_seg_y[0] + YW'(1);
    end else if (r_dir[0]) begin
      if (r_seg_y[0] == '0) begin w_out = 1'b1; w_ny = c_max_y; end
      else w_ny = r_seg_y[0] - YW'(1);
    end
  end

  assign w_wall_death = w_step && w_out && (WRAP == 0);

  // r_idx beyond length-1 (length of 1) skips the compare entirely.
  assign w_scan_hit  = (LW'(r_idx) < r_len) &&
                       (r_seg_x[r_idx] == r_seg_x[0]) && (r_seg_y[r_idx] == r_seg_y[0]);
  assign w_scan_last = (LW'(r_idx) >= (r_len - LW'(1)));
  assign w_scan_done = (r_state == S_SCAN) && !w_scan_hit && w_scan_last;

  always_comb begin
    w_body_hit = 1'b0;
    for (int i = 1; i < MAX_LEN; i++) begin
      if ((LW'(i) < r_len) && (r_seg_x[i] == bus.pix_cx) && (r_seg_y[i] == bus.pix_cy))
        w_body_hit = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= S_INIT;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (!bus.start) begin
      w_state_nxt = S_INIT;
    end else begin
      unique case (r_state)
        S_INIT: w_state_nxt = S_RUN;
        S_RUN:  if (w_step) w_state_nxt = w_wall_death ? S_DEAD : S_SCAN;
        S_SCAN: begin
          if (w_scan_hit)       w_state_nxt = S_DEAD;
          else if (w_scan_last) w_state_nxt = S_RUN;
        end
        S_DEAD: w_state_nxt = S_DEAD;
        default: w_state_nxt = S_INIT;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < MAX_LEN; i++) begin
        r_seg_x[i] <= c_init_x;
        r_seg_y[i] <= c_init_y;
      end
      r_len       <= c_init_l;
      r_idx       <= IW'(1);
      r_dir       <= INIT_DIR;
      r_last_dir  <= INIT_DIR;
      r_grow_pend <= 1'b0;
      r_dead      <= 1'b0;
      r_step_done <= 1'b0;
    end else if (!bus.start) begin
      for (int i = 0; i < MAX_LEN; i++) begin
        r_seg_x[i] <= c_init_x;
        r_seg_y[i] <= c_init_y;
      end
      r_len       <= c_init_l;
      r_idx       <= IW'(1);
      r_dir       <= INIT_DIR;
      r_last_dir  <= INIT_DIR;
      r_grow_pend <= 1'b0;
      r_dead      <= 1'b0;
      r_step_done <= 1'b0;
    end else begin
      r_step_done <= w_scan_done;
      if ((r_state != S_DEAD) && w_req_valid)
        r_dir <= bus.dir_req;

      if (w_step && !w_wall_death)
        r_grow_pend <= bus.grow;
      else if (bus.grow && (r_state != S_DEAD))
        r_grow_pend <= 1'b1;

      if (w_step) begin
        r_last_dir <= r_dir;
        if (w_wall_death) begin
          r_dead <= 1'b1;
        end else begin
          // Slots past the tail are don't-care until length reaches them.
          for (int i = 1; i < MAX_LEN; i++) begin
            r_seg_x[i] <= r_seg_x[i-1];
            r_seg_y[i] <= r_seg_y[i-1];
          end
          r_seg_x[0] <= w_nx;
          r_seg_y[0] <= w_ny;
          if (r_grow_pend && (r_len < c_max_l))
            r_len <= r_len + LW'(1);
          r_idx <= IW'(1);
        end
      end else if (r_state == S_SCAN) begin
        if (w_scan_hit)        r_dead <= 1'b1;
        else if (!w_scan_last) r_idx  <= r_idx + IW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_pix_head <= 1'b0;
      r_pix_body <= 1'b0;
    end else begin
      r_pix_head <= (r_seg_x[0] == bus.pix_cx) && (r_seg_y[0] == bus.pix_cy);
      r_pix_body <= w_body_hit;
    end
  end

  assign bus.head_x    = r_seg_x[0];
  assign bus.head_y    = r_seg_y[0];
  assign bus.length    = r_len;
  assign bus.busy      = (r_state == S_SCAN);
  assign bus.dead      = r_dead;
  assign bus.step_done = r_step_done;
  assign bus.pix_head  = r_pix_head;
  assign bus.pix_body  = r_pix_body;

endmodule

`default_nettype wire
